// File: rtl/gsm_ts_pkg.sv
// Shared types and defaults for the GSM time-shared multiplier sequencer.
// Optional feature macro used by this slice: GSM_TS_ERRCNT_EN (sync-error counter).
package gsm_ts_pkg;

    localparam int PHASES_DEF = 4;
    localparam int PH_W_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_RUN     = 2'd2
    } gsm_ts_state_e;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } gsm_ts_bank_e;

    function automatic gsm_ts_bank_e bank_flip(input gsm_ts_bank_e b);
        return (b == BANK_0) ? BANK_1 : BANK_0;
    endfunction

endpackage

// File: rtl/gsm_ts_phase_cnt.sv
// Wrapping phase counter 0..PHASES-1 with a synchronous force-to-zero.
// clr has priority over inc; at_last flags the final phase of a frame.
module gsm_ts_phase_cnt
    import gsm_ts_pkg::*;
#(
    parameter int PHASES = PHASES_DEF,
    parameter int PH_W   = PH_W_DEF
) (
    input  logic            sys_clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            inc,
    output logic [PH_W-1:0] phase,
    output logic            at_last
);

    localparam logic [PH_W-1:0] LAST = PH_W'(PHASES - 1);

    assign at_last = (phase == LAST);

    // Phase register: zero on clear, otherwise advance and wrap at LAST.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (inc) begin
            phase <= at_last ? '0 : phase + PH_W'(1);
        end
    end

endmodule

// File: rtl/gsm_ts_seq.sv
// Time-share sequencer for the GSM multiplier datapath.
// Tracks the sample strobe, drives phase/acc_clr/y_load, flags strobe
// misalignment and performs coefficient-bank swaps on frame boundaries.
// Optional feature macro: GSM_TS_ERRCNT_EN adds the saturating err_cnt port.
module gsm_ts_seq
    import gsm_ts_pkg::*;
#(
    parameter int PHASES = PHASES_DEF,
    parameter int PH_W   = PH_W_DEF,
    parameter int ERR_W  = 8
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sam_clk_en,
    input  logic             coef_swap_req,
    output logic [PH_W-1:0]  phase,
    output logic             acc_clr,
    output logic             y_load,
    output logic             coef_swap_ack,
    output logic             bank_sel,
    output logic             sync_err,
`ifdef GSM_TS_ERRCNT_EN
    output logic [ERR_W-1:0] err_cnt,
`endif
    output gsm_ts_state_e    fsm_state
);

    // Reject inconsistent parameter sets at elaboration.
    if (PH_W != $clog2(PHASES) || ERR_W < 1) begin : g_bad_cfg
        $error("gsm_ts_seq: PH_W must equal clog2(PHASES) and ERR_W >= 1");
    end

    // Swap handshake: the requester raises coef_swap_req and holds it until
    // it sees coef_swap_ack (a one-cycle pulse, coincident with the
    // bank_sel toggle). A request is latched as pending, so a misaligned
    // strobe defers it rather than losing it. After an ack the request
    // must be seen low for at least one cycle before it can re-arm.

    gsm_ts_state_e state_q, state_nxt;
    gsm_ts_bank_e  bank_q;
    logic          swap_pend_q;
    logic          swap_armed_q;

    logic          at_last;
    logic          good_stb, bad_stb, lost_stb;
    logic          swap_want, do_swap;
    logic          cnt_clr, cnt_inc;
    logic          acc_clr_d, y_load_d, sync_err_d;

    gsm_ts_phase_cnt #(
        .PHASES (PHASES),
        .PH_W   (PH_W)
    ) u_phase_cnt (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .phase   (phase),
        .at_last (at_last)
    );

    // FSM state register.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state, strobe classification, swap decision and registered-output inputs.
    always_comb begin
        state_nxt = state_q;
        good_stb  = 1'b0;
        bad_stb   = 1'b0;
        lost_stb  = 1'b0;
        do_swap   = 1'b0;
        swap_want = swap_pend_q | (coef_swap_req & swap_armed_q);

        case (state_q)
            ST_IDLE: begin
                do_swap = swap_want;
                if (enable) begin
                    state_nxt = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                do_swap = swap_want;
                if (sam_clk_en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    if (sam_clk_en) begin
                        good_stb = at_last;
                        bad_stb  = ~at_last;
                    end else if (at_last) begin
                        lost_stb  = 1'b1;
                        state_nxt = ST_ACQUIRE;
                    end
                end
                do_swap = good_stb & swap_want;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (!enable) begin
            state_nxt = ST_IDLE;
        end

        // Phase holds 0 outside RUN and on the first RUN cycle; a misaligned
        // strobe restarts the frame at 0.
        cnt_clr = (state_nxt != ST_RUN) | (state_q != ST_RUN) | bad_stb;
        cnt_inc = ~cnt_clr;

        // acc_clr tracks the registered (state, phase) pair it describes.
        acc_clr_d  = (state_nxt == ST_RUN) & (cnt_clr | at_last);
        // Only a good strobe closes a frame that ran 0..PHASES-1 in full;
        // the acquire entry and forced restarts never load y.
        y_load_d   = good_stb;
        sync_err_d = bad_stb | lost_stb;
    end

    // Registered outputs and swap bookkeeping.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_clr       <= 1'b0;
            y_load        <= 1'b0;
            sync_err      <= 1'b0;
            coef_swap_ack <= 1'b0;
            bank_q        <= BANK_0;
            swap_pend_q   <= 1'b0;
            swap_armed_q  <= 1'b1;
        end else begin
            acc_clr       <= acc_clr_d;
            y_load        <= y_load_d;
            sync_err      <= sync_err_d;
            coef_swap_ack <= do_swap;
            if (do_swap) begin
                bank_q       <= bank_flip(bank_q);
                swap_pend_q  <= 1'b0;
                swap_armed_q <= 1'b0;
            end else begin
                if (coef_swap_req && swap_armed_q) begin
                    swap_pend_q <= 1'b1;
                end
                if (!coef_swap_req) begin
                    swap_armed_q <= 1'b1;
                end
            end
        end
    end

`ifdef GSM_TS_ERRCNT_EN
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Saturating count of sync errors; cleared only by reset.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (sync_err_d && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end
`endif

    assign bank_sel  = bank_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_gsm_ts_seq.sv
// Directed self-checking bench for gsm_ts_seq (PHASES=4, ERR_W=8).
// err_cnt checks are compiled in when GSM_TS_ERRCNT_EN is defined.
module tb_gsm_ts_seq;
    import gsm_ts_pkg::*;

    logic          sys_clk;
    logic          reset_n;
    logic          enable;
    logic          sam_clk_en;
    logic          coef_swap_req;
    logic [1:0]    phase;
    logic          acc_clr;
    logic          y_load;
    logic          coef_swap_ack;
    logic          bank_sel;
    logic          sync_err;
`ifdef GSM_TS_ERRCNT_EN
    logic [7:0]    err_cnt;
`endif
    gsm_ts_state_e fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    int n_se  = 0;

    gsm_ts_seq #(
        .PHASES (4),
        .PH_W   (2),
        .ERR_W  (8)
    ) dut (
        .sys_clk       (sys_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .sam_clk_en    (sam_clk_en),
        .coef_swap_req (coef_swap_req),
        .phase         (phase),
        .acc_clr       (acc_clr),
        .y_load        (y_load),
        .coef_swap_ack (coef_swap_ack),
        .bank_sel      (bank_sel),
        .sync_err      (sync_err),
`ifdef GSM_TS_ERRCNT_EN
        .err_cnt       (err_cnt),
`endif
        .fsm_state     (fsm_state)
    );

    // Clock
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the per-cycle datapath controls in one call.
    task automatic chk_ctl(input string tag, input logic [1:0] ph, input logic ac,
                           input logic yl, input logic se);
        chk({tag, ".phase"},    {30'd0, phase}, {30'd0, ph});
        chk({tag, ".acc_clr"},  {31'd0, acc_clr}, {31'd0, ac});
        chk({tag, ".y_load"},   {31'd0, y_load}, {31'd0, yl});
        chk({tag, ".sync_err"}, {31'd0, sync_err}, {31'd0, se});
    endtask

    task automatic chk_swap(input string tag, input logic ack, input logic bank);
        chk({tag, ".ack"},  {31'd0, coef_swap_ack}, {31'd0, ack});
        chk({tag, ".bank"}, {31'd0, bank_sel}, {31'd0, bank});
    endtask

    // Apply the strobe for one clock and sample just after the edge.
    task automatic step(input logic s);
        sam_clk_en = s;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        sam_clk_en    = 1'b0;
        coef_swap_req = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;

        // Reset state
        chk_ctl("rst", 2'd0, 1'b0, 1'b0, 1'b0);
        chk_swap("rst", 1'b0, 1'b0);
        chk("rst.state", fsm_state, ST_IDLE);
`ifdef GSM_TS_ERRCNT_EN
        chk("rst.err_cnt", err_cnt, 0);
`endif
        reset_n = 1'b1;
        step(1'b0);
        chk("idle.state", fsm_state, ST_IDLE);

        // Acquire: phase held 0 until a strobe
        enable = 1'b1;
        step(1'b0);
        chk("acq.state", fsm_state, ST_ACQUIRE);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk("acq.hold.state", fsm_state, ST_ACQUIRE);
            chk("acq.hold.phase", phase, 0);
        end

        // Scenario 1: aligned strobes, first y_load at second frame start
        step(1'b1);
        chk("s1.state", fsm_state, ST_RUN);
        chk_ctl("s1.f0", 2'd0, 1'b1, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int p = 1; p < 4; p++) begin
                step(1'b0);
                chk_ctl("s1.mid", 2'(p), 1'b0, 1'b0, 1'b0);
            end
            step(1'b1);
            chk_ctl("s1.wrap", 2'd0, 1'b1, 1'b1, 1'b0);
        end

        // Scenario 2: early strobe at phase 1
        step(1'b0);
        chk("s2.pre", phase, 1);
        step(1'b1);
        chk_ctl("s2.err", 2'd0, 1'b1, 1'b0, 1'b1);
        chk("s2.state", fsm_state, ST_RUN);
`ifdef GSM_TS_ERRCNT_EN
        chk("s2.err_cnt", err_cnt, 1);
`endif
        step(1'b0);
        chk_ctl("s2.after", 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0);
        step(1'b0);
        chk("s2.ph3", phase, 3);
        step(1'b1);
        chk_ctl("s2.restart_done", 2'd0, 1'b1, 1'b1, 1'b0);

        // Scenario 3: missing strobe at phase 3
        step(1'b0);
        step(1'b0);
        step(1'b0);
        chk("s3.ph3", phase, 3);
        step(1'b0);
        chk_ctl("s3.lost", 2'd0, 1'b0, 1'b0, 1'b1);
        chk("s3.state", fsm_state, ST_ACQUIRE);
`ifdef GSM_TS_ERRCNT_EN
        chk("s3.err_cnt", err_cnt, 2);
`endif
        step(1'b0);
        step(1'b0);
        chk_ctl("s3.hold", 2'd0, 1'b0, 1'b0, 1'b0);
        chk("s3.hold.state", fsm_state, ST_ACQUIRE);
        step(1'b1);
        chk_ctl("s3.reacq", 2'd0, 1'b1, 1'b0, 1'b0);
        chk("s3.reacq.state", fsm_state, ST_RUN);

        // Scenario 4: swap requested at phase 1, taken after the good strobe
        step(1'b0);
        chk("s4.ph1", phase, 1);
        coef_swap_req = 1'b1;
        step(1'b0);
        chk_swap("s4.ph2", 1'b0, 1'b0);
        step(1'b0);
        chk_swap("s4.ph3", 1'b0, 1'b0);
        step(1'b1);
        chk_swap("s4.ack", 1'b1, 1'b1);
        chk_ctl("s4.wrap", 2'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0);
        chk_swap("s4.hold1", 1'b0, 1'b1);
        step(1'b0);
        chk_swap("s4.hold2", 1'b0, 1'b1);
        coef_swap_req = 1'b0;
        step(1'b0);
        step(1'b1);
        chk_swap("s4.no_second", 1'b0, 1'b1);

        // Deferred swap: request coincides with a misaligned strobe
        step(1'b0);
        coef_swap_req = 1'b1;
        step(1'b1);
        chk_swap("def.bad", 1'b0, 1'b1);
        chk("def.sync_err", sync_err, 1);
`ifdef GSM_TS_ERRCNT_EN
        chk("def.err_cnt", err_cnt, 3);
`endif
        step(1'b0);
        step(1'b0);
        step(1'b0);
        chk_swap("def.wait", 1'b0, 1'b1);
        step(1'b1);
        chk_swap("def.ack", 1'b1, 1'b0);
        coef_swap_req = 1'b0;

        // Scenario 5: reset at phase 2 with a swap pending
        coef_swap_req = 1'b1;
        step(1'b0);
        step(1'b0);
        chk("s5.ph2", phase, 2);
        coef_swap_req = 1'b0;
        reset_n       = 1'b0;
        #1;
        chk_ctl("s5.rst", 2'd0, 1'b0, 1'b0, 1'b0);
        chk_swap("s5.rst", 1'b0, 1'b0);
        chk("s5.rst.state", fsm_state, ST_IDLE);
`ifdef GSM_TS_ERRCNT_EN
        chk("s5.rst.err_cnt", err_cnt, 0);
`endif
        @(posedge sys_clk);
        #1;
        reset_n = 1'b1;
        step(1'b0);
        chk("s5.acq", fsm_state, ST_ACQUIRE);
        chk_swap("s5.acq", 1'b0, 1'b0);
        step(1'b0);
        chk_swap("s5.acq2", 1'b0, 1'b0);
        step(1'b1);
        chk_ctl("s5.f0", 2'd0, 1'b1, 1'b0, 1'b0);
        for (int p = 1; p < 4; p++) begin
            step(1'b0);
            chk_ctl("s5.mid", 2'(p), 1'b0, 1'b0, 1'b0);
        end
        step(1'b1);
        chk_ctl("s5.wrap", 2'd0, 1'b1, 1'b1, 1'b0);
        chk_swap("s5.wrap", 1'b0, 1'b0);

        // Enable low forces IDLE; swap in IDLE is taken the next cycle
        enable = 1'b0;
        step(1'b0);
        chk("dis.state", fsm_state, ST_IDLE);
        chk_ctl("dis", 2'd0, 1'b0, 1'b0, 1'b0);
        coef_swap_req = 1'b1;
        step(1'b0);
        chk_swap("idle.ack", 1'b1, 1'b1);
        coef_swap_req = 1'b0;
        step(1'b0);
        chk_swap("idle.after", 1'b0, 1'b1);

        // Scenario 6: 300 misaligned strobes
        enable = 1'b1;
        step(1'b0);
        step(1'b1);
        chk("s6.state", fsm_state, ST_RUN);
        for (int i = 0; i < 300; i++) begin
            step(1'b1);
            n_se += int'(sync_err);
`ifdef GSM_TS_ERRCNT_EN
            if (i == 99)  chk("s6.err_cnt100", err_cnt, 100);
            if (i == 253) chk("s6.err_cnt254", err_cnt, 254);
`endif
        end
        chk("s6.sync_err_pulses", n_se, 300);
        chk("s6.phase", phase, 0);
`ifdef GSM_TS_ERRCNT_EN
        chk("s6.err_cnt_sat", err_cnt, 255);
        step(1'b1);
        chk("s6.err_cnt_hold", err_cnt, 255);
`endif
        sam_clk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
